// File: rtl/sodor_state_diff_pkg.sv
// -----------------------------------------------------------------------------
// sodor_state_diff_pkg
// Shared types and helpers for the multi-cycle state-diff scanner.
//   state_e   : scanner FSM states (idle, chunk scan, result hold)
//   nchunk_f  : number of CHUNK_W-wide chunks in a STATE_W-wide vector
//   idx_w_f   : width of the chunk index / mismatch count fields
//   result_t  : verdict record {equal, first_idx, mis_cnt} for the default
//               geometry (1024-bit state, 64-bit chunks)
// Optional feature macro used elsewhere in the slice: STATE_DIFF_MASK_EN.
// -----------------------------------------------------------------------------
package sodor_state_diff_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_RESULT = 2'd2
   } state_e;

   function automatic int nchunk_f(input int state_w, input int chunk_w);
      return state_w / chunk_w;
   endfunction

   // One extra bit so the "no mismatch" sentinel NCHUNK is representable.
   function automatic int idx_w_f(input int nchunk);
      return $clog2(nchunk) + 1;
   endfunction

   localparam int DEF_STATE_W = 1024;
   localparam int DEF_CHUNK_W = 64;
   localparam int DEF_NCHUNK  = nchunk_f(DEF_STATE_W, DEF_CHUNK_W);
   localparam int DEF_IDX_W   = idx_w_f(DEF_NCHUNK);

   typedef struct packed {
      logic                 equal;
      logic [DEF_IDX_W-1:0] first_idx;
      logic [DEF_IDX_W-1:0] mis_cnt;
   } result_t;

endpackage

// File: rtl/sodor_chunk_cmp.sv
// -----------------------------------------------------------------------------
// sodor_chunk_cmp
// Combinational compare of one CHUNK_W-wide slice of the two state snapshots.
// Ports:
//   chunk_a    in  CHUNK_W  slice of copy A snapshot
//   chunk_b    in  CHUNK_W  slice of copy B snapshot
//   chunk_mask in  CHUNK_W  compare-enable bits (only with STATE_DIFF_MASK_EN)
//   mismatch   out 1        1 when any (enabled) bit differs
// Macro: STATE_DIFF_MASK_EN adds the mask input; otherwise all bits compare.
// -----------------------------------------------------------------------------
module sodor_chunk_cmp #(
   parameter int CHUNK_W = 64
) (
   input  logic [CHUNK_W-1:0] chunk_a,
   input  logic [CHUNK_W-1:0] chunk_b,
`ifdef STATE_DIFF_MASK_EN
   input  logic [CHUNK_W-1:0] chunk_mask,
`endif
   output logic               mismatch
);

`ifdef STATE_DIFF_MASK_EN
   // Cleared mask bits (free-running counters and the like) never mismatch.
   assign mismatch = |((chunk_a ^ chunk_b) & chunk_mask);
`else
   assign mismatch = |(chunk_a ^ chunk_b);
`endif

endmodule

// File: rtl/sodor_state_diff_scanner.sv
// -----------------------------------------------------------------------------
// sodor_state_diff_scanner
// Snapshots the flattened architectural state of two core copies and compares
// them one chunk per cycle (chunk 0 = bits [CHUNK_W-1:0]), then presents an
// equality verdict, lowest mismatching chunk index and mismatch count on a
// valid/ready result interface.
// Ports:
//   clock          in  1        rising-edge clock
//   reset_n        in  1        asynchronous active-low reset
//   state_a        in  STATE_W  flattened state, copy A (src)
//   state_b        in  STATE_W  flattened state, copy B (tgt)
//   state_mask     in  STATE_W  compare-enable bits (STATE_DIFF_MASK_EN only)
//   start_valid    in  1        snapshot-and-compare request
//   start_ready    out 1        high in IDLE; request taken on valid&&ready
//   res_valid      out 1        result held until res_valid&&res_ready
//   res_ready      in  1        consumer accepts result
//   res_equal      out 1        all chunks matched
//   res_first_idx  out IDX_W    lowest mismatching chunk, NCHUNK if none
//   res_mis_cnt    out IDX_W    number of mismatching chunks
//   busy           out 1        high while scanning
// Macro: STATE_DIFF_MASK_EN enables the per-bit compare mask.
// Latency: request accepted in cycle t, res_valid first high in t+NCHUNK+1.
// -----------------------------------------------------------------------------
module sodor_state_diff_scanner
   import sodor_state_diff_pkg::*;
#(
   parameter  int STATE_W = DEF_STATE_W,
   parameter  int CHUNK_W = DEF_CHUNK_W,
   localparam int NCHUNK  = nchunk_f(STATE_W, CHUNK_W),
   localparam int IDX_W   = idx_w_f(NCHUNK)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [STATE_W-1:0] state_a,
   input  logic [STATE_W-1:0] state_b,
`ifdef STATE_DIFF_MASK_EN
   input  logic [STATE_W-1:0] state_mask,
`endif
   input  logic               start_valid,
   output logic               start_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_equal,
   output logic [IDX_W-1:0]   res_first_idx,
   output logic [IDX_W-1:0]   res_mis_cnt,
   output logic               busy
);

   localparam int               PTR_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCHUNK - 1);
   localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NCHUNK);

   generate
      if ((STATE_W % CHUNK_W) != 0) begin : g_bad_geometry
         $error("STATE_W must be a multiple of CHUNK_W");
      end
   endgenerate

   // Count cannot actually reach NCHUNK+1, but it is kept saturating so a
   // wider state never wraps the field.
   function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
      if (v >= IDX_NONE) begin
         return v;
      end
      return v + IDX_W'(1);
   endfunction

   state_e             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   first_q;
   logic               equal_q;
   logic [IDX_W-1:0]   cnt_nxt;
   logic               accept;
   logic               mismatch;

   logic [CHUNK_W-1:0] snap_a [NCHUNK];
   logic [CHUNK_W-1:0] snap_b [NCHUNK];
`ifdef STATE_DIFF_MASK_EN
   logic [CHUNK_W-1:0] snap_m [NCHUNK];
`endif

   assign accept      = start_valid && (state_q == S_IDLE);
   assign start_ready = (state_q == S_IDLE);
   assign busy        = (state_q == S_SCAN);
   assign res_valid   = (state_q == S_RESULT);

   assign res_equal     = equal_q;
   assign res_first_idx = first_q;
   assign res_mis_cnt   = cnt_q;

   // ---- capture: snapshots are data-only, no reset needed ----
   always_ff @(posedge clock) begin
      if (accept) begin
         for (int i = 0; i < NCHUNK; i++) begin
            snap_a[i] <= state_a[i*CHUNK_W +: CHUNK_W];
            snap_b[i] <= state_b[i*CHUNK_W +: CHUNK_W];
`ifdef STATE_DIFF_MASK_EN
            snap_m[i] <= state_mask[i*CHUNK_W +: CHUNK_W];
`endif
         end
      end
   end

   // ---- compare: single comparator steered by the chunk pointer ----
   sodor_chunk_cmp #(
      .CHUNK_W    (CHUNK_W)
   ) u_cmp (
      .chunk_a    (snap_a[ptr_q]),
      .chunk_b    (snap_b[ptr_q]),
`ifdef STATE_DIFF_MASK_EN
      .chunk_mask (snap_m[ptr_q]),
`endif
      .mismatch   (mismatch)
   );

   always_comb begin
      cnt_nxt = cnt_q;
      if (mismatch) begin
         cnt_nxt = sat_inc(cnt_q);
      end
   end

   // ---- control: FSM, pointer and result accumulators ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         first_q <= '0;
         equal_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_valid) begin
                  state_q <= S_SCAN;
                  ptr_q   <= '0;
                  cnt_q   <= '0;
                  first_q <= IDX_NONE;
                  equal_q <= 1'b0;
               end
            end
            S_SCAN: begin
               cnt_q <= cnt_nxt;
               if (mismatch && (first_q == IDX_NONE)) begin
                  first_q <= IDX_W'(ptr_q);
               end
               if (ptr_q == PTR_LAST) begin
                  state_q <= S_RESULT;
                  equal_q <= (cnt_nxt == '0);
               end else begin
                  ptr_q <= ptr_q + PTR_W'(1);
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sodor_state_diff_scanner.sv
// -----------------------------------------------------------------------------
// tb_sodor_state_diff_scanner
// Directed scoreboard bench: the driver pushes the hand-computed verdict and
// the acceptance cycle for each request; a negedge monitor checks result
// latency, field stability while stalled, the verdict on each handshake and
// the return to IDLE after it.
// Macro: STATE_DIFF_MASK_EN enables the masked-compare vectors.
// -----------------------------------------------------------------------------
module tb_sodor_state_diff_scanner;
   import sodor_state_diff_pkg::*;

   localparam int STATE_W = 1024;
   localparam int CHUNK_W = 64;
   localparam int NCHUNK  = 16;
   localparam int IDX_W   = 5;
   localparam int LAT     = NCHUNK + 1;

   logic               clock = 1'b0;
   logic               reset_n;
   logic [STATE_W-1:0] state_a;
   logic [STATE_W-1:0] state_b;
`ifdef STATE_DIFF_MASK_EN
   logic [STATE_W-1:0] state_mask;
`endif
   logic               start_valid;
   logic               start_ready;
   logic               res_valid;
   logic               res_ready;
   logic               res_equal;
   logic [IDX_W-1:0]   res_first_idx;
   logic [IDX_W-1:0]   res_mis_cnt;
   logic               busy;

   always #5 clock = ~clock;

   sodor_state_diff_scanner #(
      .STATE_W       (STATE_W),
      .CHUNK_W       (CHUNK_W)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .state_a       (state_a),
      .state_b       (state_b),
`ifdef STATE_DIFF_MASK_EN
      .state_mask    (state_mask),
`endif
      .start_valid   (start_valid),
      .start_ready   (start_ready),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_equal     (res_equal),
      .res_first_idx (res_first_idx),
      .res_mis_cnt   (res_mis_cnt),
      .busy          (busy)
   );

   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc      = 0;
   result_t exp_q [$];
   int      acc_q [$];

   logic [STATE_W-1:0] va;
   logic [STATE_W-1:0] vb;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---- monitor ----
   logic             prev_valid = 1'b0;
   logic             prev_hs    = 1'b0;
   logic             prev_eq    = 1'b0;
   logic [IDX_W-1:0] prev_first = '0;
   logic [IDX_W-1:0] prev_cnt   = '0;

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (prev_hs) begin
            check("idle_after_hs_res_valid", {31'd0, res_valid}, 32'd0);
            check("idle_after_hs_start_ready", {31'd0, start_ready}, 32'd1);
         end
         if (res_valid && prev_valid && !prev_hs) begin
            check("stall_equal_stable", {31'd0, res_equal}, {31'd0, prev_eq});
            check("stall_first_stable", {27'd0, res_first_idx}, {27'd0, prev_first});
            check("stall_cnt_stable", {27'd0, res_mis_cnt}, {27'd0, prev_cnt});
         end
         if (res_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: res_valid=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
               check("latency", 32'(cyc - acc_q.pop_front()), 32'(LAT));
            end
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_handshake: result accepted with empty scoreboard (cycle %0d)", cyc);
            end else begin
               result_t e;
               e = exp_q.pop_front();
               check("res_equal", {31'd0, res_equal}, {31'd0, e.equal});
               check("res_first_idx", {27'd0, res_first_idx}, {27'd0, e.first_idx});
               check("res_mis_cnt", {27'd0, res_mis_cnt}, {27'd0, e.mis_cnt});
            end
         end
         prev_valid = res_valid;
         prev_hs    = res_valid && res_ready;
         prev_eq    = res_equal;
         prev_first = res_first_idx;
         prev_cnt   = res_mis_cnt;
      end else begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end
   end

   // ---- driver ----
   task automatic wait_idle();
      int n = 0;
      while (start_ready !== 1'b1 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (start_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: start_ready=%b after %0d cycles, required 1", start_ready, n);
      end
   endtask

   task automatic launch(input logic [STATE_W-1:0] a, input logic [STATE_W-1:0] b,
                         input logic eq, input logic [IDX_W-1:0] first,
                         input logic [IDX_W-1:0] cnt);
      result_t e;
      wait_idle();
      state_a     = a;
      state_b     = b;
      start_valid = 1'b1;
      e.equal     = eq;
      e.first_idx = first;
      e.mis_cnt   = cnt;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      @(posedge clock);
      #1;
      start_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      state_a     = '0;
      state_b     = '0;
      start_valid = 1'b0;
      res_ready   = 1'b1;
      reset_n     = 1'b0;
`ifdef STATE_DIFF_MASK_EN
      state_mask  = '1;
`endif
      #12;
      check("rst_start_ready", {31'd0, start_ready}, 32'd1);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_equal", {31'd0, res_equal}, 32'd0);
      check("rst_res_first_idx", {27'd0, res_first_idx}, 32'd0);
      check("rst_res_mis_cnt", {27'd0, res_mis_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // identical vectors
      va = {128{8'hA5}};
      launch(va, va, 1'b1, 5'd16, 5'd0);

      // bit 70 (chunk 1) and bit 1023 (chunk 15) differ
      vb = va;
      vb[70]   = ~vb[70];
      vb[1023] = ~vb[1023];
      launch(va, vb, 1'b0, 5'd1, 5'd2);

      // input isolation: state_b flips right after capture
      va = {16{64'h0123_4567_89AB_CDEF}};
      launch(va, va, 1'b1, 5'd16, 5'd0);
      check("busy_in_scan", {31'd0, busy}, 32'd1);
      state_b = ~va;

      // result stall with ignored start requests; chunks 0, 3, 9 differ
      wait_idle();
      res_ready = 1'b0;
      vb = va;
      vb[5]   = ~vb[5];
      vb[200] = ~vb[200];
      vb[600] = ~vb[600];
      launch(va, vb, 1'b0, 5'd0, 5'd3);
      begin
         int n = 0;
         while (res_valid !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
         end
         if (res_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_result: res_valid=%b after %0d cycles, required 1", res_valid, n);
         end
      end
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'b1;
         check("start_ready_in_result", {31'd0, start_ready}, 32'd0);
         @(posedge clock);
         #1;
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;

      // reset during scan cycle 8 discards the pending result
      va = {32{32'hDEAD_BEEF}};
      launch(va, ~va, 1'b0, 5'd0, 5'd16);
      repeat (8) @(posedge clock);
      #2;
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("reset_mid_busy", {31'd0, busy}, 32'd0);
      check("reset_mid_res_valid", {31'd0, res_valid}, 32'd0);
      check("reset_mid_start_ready", {31'd0, start_ready}, 32'd1);
      exp_q.delete();
      acc_q.delete();
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // fresh start after reset: only chunk 15 (bit 960) differs
      vb = va;
      vb[960] = ~vb[960];
      launch(va, vb, 1'b0, 5'd15, 5'd1);

      // every chunk differs
      launch(va, ~va, 1'b0, 5'd0, 5'd16);

`ifdef STATE_DIFF_MASK_EN
      // masked-out bit 70 never mismatches
      wait_idle();
      va = {128{8'h3C}};
      vb = va;
      vb[70] = ~vb[70];
      state_mask     = '1;
      state_mask[70] = 1'b0;
      launch(va, vb, 1'b1, 5'd16, 5'd0);
      // an unmasked neighbour still does
      wait_idle();
      vb[71] = ~vb[71];
      launch(va, vb, 1'b0, 5'd1, 5'd1);
      wait_idle();
      state_mask = '1;
`endif

      wait_idle();
      repeat (3) @(posedge clock);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("final_res_valid", {31'd0, res_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
